// File: rtl/easy_eth_frame_gen.sv
// easy_eth_frame_gen
//   AXI-stream Ethernet test-frame generator, single clock domain.
//   Emits runs of frames with a programmable beat count, inter-frame gap,
//   last-beat byte count and frame count. Every byte of beat i carries
//   {i[3:0], i[3:0]}. All outputs are registered.
//
//   Optional feature macro: EASY_ETH_GEN_THROTTLE_EN
//     defined   -> a 16-bit LFSR inserts random source-side bubbles in SEND
//     undefined -> valid stays high for the whole frame while in SEND
//
// Ports
//   wClk, wRst       clock, synchronous active-high reset
//   wStart           level run enable; low stops at the next frame boundary
//   bFrame_len       beats per frame (0 treated as 1)
//   bGap_len         idle cycles between frames (0 = back-to-back)
//   bLast_bytes      valid bytes in the last beat (0 or >KEEP_W = full beat)
//   bFrame_num       frames per run (0 = unlimited)
//   wAxis_eth_*      AXI-stream master (valid/ready/data/keep/last)
//   wBusy            high whenever the generator is not idle
//   wDone            one-cycle pulse when a run finishes
//   bFrame_cnt       frames completed in the current run (wraps)
module easy_eth_frame_gen #(
    parameter int DATA_W = 128,
    parameter int KEEP_W = DATA_W / 8,
    parameter int LEN_W  = 16
) (
    input  logic              wClk,
    input  logic              wRst,
    input  logic              wStart,
    input  logic [LEN_W-1:0]  bFrame_len,
    input  logic [LEN_W-1:0]  bGap_len,
    input  logic [7:0]        bLast_bytes,
    input  logic [LEN_W-1:0]  bFrame_num,
    output logic              wAxis_eth_valid,
    input  logic              wAxis_eth_ready,
    output logic [DATA_W-1:0] bAxis_eth_data,
    output logic [KEEP_W-1:0] bAxis_eth_keep,
    output logic              wAxis_eth_last,
    output logic              wBusy,
    output logic              wDone,
    output logic [LEN_W-1:0]  bFrame_cnt
);

    localparam int unsigned KEEP_U = KEEP_W;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  beatIdx;
    logic [LEN_W-1:0]  lastIdx;    // latched frame length minus one
    logic [KEEP_W-1:0] lastKeep;   // latched keep mask for the last beat
    logic [LEN_W-1:0]  gapLen;     // latched gap length
    logic [LEN_W-1:0]  gapCnt;

    logic [LEN_W-1:0]  newLastIdx;
    logic [KEEP_W-1:0] newLastKeep;
    logic [LEN_W-1:0]  nextIdx;
    logic [LEN_W-1:0]  nextCnt;
    logic              handshake;
    logic              lastBeat;
    logic              runEnd;
    logic              loadFrame;
    logic              presentOk;

    function automatic logic [DATA_W-1:0] beatData(input logic [LEN_W-1:0] idx);
        return {KEEP_W{{idx[3:0], idx[3:0]}}};
    endfunction

`ifdef EASY_ETH_GEN_THROTTLE_EN
    // x^16 + x^14 + x^13 + x^11 + 1, free-running; bit 0 gates beat presentation
    logic [15:0] lfsr;

    always_ff @(posedge wClk) begin
        if (wRst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign presentOk = lfsr[0];
`else
    assign presentOk = 1'b1;
`endif

    always_comb begin
        newLastIdx = (bFrame_len == '0) ? '0 : bFrame_len - 1'b1;
        newLastKeep = '1;
        if ((bLast_bytes != 8'd0) && (32'(bLast_bytes) <= KEEP_U)) begin
            for (int unsigned k = 0; k < KEEP_U; k++) begin
                newLastKeep[k] = (k < 32'(bLast_bytes));
            end
        end
        nextIdx   = beatIdx + 1'b1;
        nextCnt   = bFrame_cnt + 1'b1;
        handshake = wAxis_eth_valid & wAxis_eth_ready;
        lastBeat  = (beatIdx == lastIdx);
        runEnd    = ((bFrame_num != '0) && (nextCnt == bFrame_num)) || !wStart;
        // Every path into SEND (start, back-to-back restart, end of gap) shares one frame-load
        loadFrame = ((state == IDLE) && wStart)
                 || ((state == SEND) && handshake && lastBeat && !runEnd && (gapLen == '0))
                 || ((state == GAP) && wStart && (gapCnt == gapLen - 1'b1));
    end

    always_ff @(posedge wClk) begin
        if (wRst) begin
            state           <= IDLE;
            wAxis_eth_valid <= 1'b0;
            wAxis_eth_last  <= 1'b0;
            bAxis_eth_data  <= '0;
            bAxis_eth_keep  <= '1;
            wBusy           <= 1'b0;
            wDone           <= 1'b0;
            bFrame_cnt      <= '0;
            beatIdx         <= '0;
            lastIdx         <= '0;
            lastKeep        <= '1;
            gapLen          <= '0;
            gapCnt          <= '0;
        end else begin
            wDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (wStart) begin
                        state      <= SEND;
                        wBusy      <= 1'b1;
                        bFrame_cnt <= '0;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        if (lastBeat) begin
                            bFrame_cnt <= nextCnt;
                            if (runEnd) begin
                                state           <= IDLE;
                                wBusy           <= 1'b0;
                                wDone           <= 1'b1;
                                wAxis_eth_valid <= 1'b0;
                                wAxis_eth_last  <= 1'b0;
                            end else if (gapLen != '0) begin
                                state           <= GAP;
                                gapCnt          <= '0;
                                wAxis_eth_valid <= 1'b0;
                                wAxis_eth_last  <= 1'b0;
                            end
                        end else begin
                            beatIdx         <= nextIdx;
                            bAxis_eth_data  <= beatData(nextIdx);
                            bAxis_eth_keep  <= (nextIdx == lastIdx) ? lastKeep : '1;
                            wAxis_eth_last  <= (nextIdx == lastIdx);
                            wAxis_eth_valid <= presentOk;
                        end
                    end else if (!wAxis_eth_valid && presentOk) begin
                        // a beat withheld by throttling is presented once allowed
                        wAxis_eth_valid <= 1'b1;
                    end
                end
                GAP: begin
                    if (!wStart) begin
                        state <= IDLE;
                        wBusy <= 1'b0;
                        wDone <= 1'b1;
                    end else if (gapCnt == gapLen - 1'b1) begin
                        state <= SEND;
                    end else begin
                        gapCnt <= gapCnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Frame load: latch config and present beat 0 (overrides the case above)
            if (loadFrame) begin
                beatIdx         <= '0;
                lastIdx         <= newLastIdx;
                lastKeep        <= newLastKeep;
                gapLen          <= bGap_len;
                bAxis_eth_data  <= '0;
                bAxis_eth_keep  <= (newLastIdx == '0) ? newLastKeep : '1;
                wAxis_eth_last  <= (newLastIdx == '0);
                wAxis_eth_valid <= presentOk;
            end
        end
    end

endmodule

// File: tb/tb_easy_eth_frame_gen.sv
// tb_easy_eth_frame_gen
//   Directed bench for easy_eth_frame_gen (default build, DATA_W = 128).
//   Expected beats are queued when a frame is requested and popped on each
//   observed handshake; counters track gaps, lasts and done pulses.
module tb_easy_eth_frame_gen;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [15:0]  frameLen = 16'd0;
    logic [15:0]  gapLen = 16'd0;
    logic [7:0]   lastBytes = 8'd0;
    logic [15:0]  frameNum = 16'd0;
    logic         valid;
    logic         ready = 1'b1;
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic         busy;
    logic         done;
    logic [15:0]  frameCnt;

    easy_eth_frame_gen #(.DATA_W(128), .LEN_W(16)) dut (
        .wClk            (clk),
        .wRst            (rst),
        .wStart          (start),
        .bFrame_len      (frameLen),
        .bGap_len        (gapLen),
        .bLast_bytes     (lastBytes),
        .bFrame_num      (frameNum),
        .wAxis_eth_valid (valid),
        .wAxis_eth_ready (ready),
        .bAxis_eth_data  (data),
        .bAxis_eth_keep  (keep),
        .wAxis_eth_last  (last),
        .wBusy           (busy),
        .wDone           (done),
        .bFrame_cnt      (frameCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } beat_t;

    beat_t sb[$];
    int    gapQ[$];
    int    nTests = 0;
    int    nFail = 0;
    int    hsCnt, lastCnt, validCnt, doneCnt, gapRun;
    bit    measuring;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nTests++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] keepModel(input int lb);
        logic [15:0] m = '0;
        if (lb == 0 || lb > 16) return 16'hFFFF;
        for (int i = 0; i < lb; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic pushFrame(input int len, input int lb);
        int    eff;
        beat_t e;
        logic [7:0] b;
        eff = (len == 0) ? 1 : len;
        for (int i = 0; i < eff; i++) begin
            b   = 8'((i % 16) * 17);
            e.d = {16{b}};
            e.k = (i == eff - 1) ? keepModel(lb) : 16'hFFFF;
            e.l = (i == eff - 1);
            sb.push_back(e);
        end
    endtask

    task automatic clr();
        hsCnt = 0; lastCnt = 0; validCnt = 0; doneCnt = 0; gapRun = 0;
        measuring = 0;
        gapQ.delete();
    endtask

    // Observe the current cycle (inputs already driven), then advance one clock.
    task automatic tick();
        beat_t e;
        if (measuring && valid) begin
            gapQ.push_back(gapRun);
            measuring = 0;
        end else if (measuring) begin
            gapRun++;
        end
        if (valid) validCnt++;
        if (done) doneCnt++;
        if (valid && ready) begin
            hsCnt++;
            if (last) begin
                lastCnt++;
                measuring = 1;
                gapRun = 0;
            end
            check("sb_nonempty", 128'(sb.size() != 0), 128'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("beat_data", data, e.d);
                check("beat_keep", 128'(keep), 128'(e.k));
                check("beat_last", 128'(last), 128'(e.l));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check(tag, 128'(done), 128'd1);
    endtask

    task automatic waitByte(input string tag, input logic [7:0] b, input int budget);
        int n = 0;
        while (!(valid && data[7:0] == b) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 128'(valid && data[7:0] == b), 128'd1);
    endtask

    initial begin
        logic [127:0] hd;
        logic [15:0]  hk;
        int n;
        clr();
        #1;
        // reset
        tick();
        tick();
        check("rst_valid", 128'(valid), 128'd0);
        check("rst_last", 128'(last), 128'd0);
        check("rst_data", data, 128'd0);
        check("rst_keep", 128'(keep), 128'hFFFF);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_cnt", 128'(frameCnt), 128'd0);
        rst = 1'b0;
        tick();

        // 1: len4 gap2 lb15 num3
        clr();
        frameLen = 16'd4; gapLen = 16'd2; lastBytes = 8'd15; frameNum = 16'd3;
        for (int f = 0; f < 3; f++) pushFrame(4, 15);
        start = 1'b1;
        waitDone("t1_done", 100);
        start = 1'b0;
        tick();
        tick();
        check("t1_done_cnt", 128'(doneCnt), 128'd1);
        check("t1_hs", 128'(hsCnt), 128'd12);
        check("t1_frame_cnt", 128'(frameCnt), 128'd3);
        check("t1_busy", 128'(busy), 128'd0);
        check("t1_sb_empty", 128'(sb.size()), 128'd0);
        check("t1_ngaps", 128'(gapQ.size()), 128'd2);
        foreach (gapQ[i]) check("t1_gap", 128'(gapQ[i]), 128'd2);

        // 2: len3 gap0 num2, back-to-back
        clr();
        frameLen = 16'd3; gapLen = 16'd0; lastBytes = 8'd16; frameNum = 16'd2;
        for (int f = 0; f < 2; f++) pushFrame(3, 16);
        start = 1'b1;
        waitDone("t2_done", 100);
        start = 1'b0;
        tick();
        check("t2_valid_cycles", 128'(validCnt), 128'd6);
        check("t2_lasts", 128'(lastCnt), 128'd2);
        check("t2_ngaps", 128'(gapQ.size()), 128'd1);
        foreach (gapQ[i]) check("t2_gap", 128'(gapQ[i]), 128'd0);
        check("t2_frame_cnt", 128'(frameCnt), 128'd2);

        // 3: len5, ready low for 4 cycles on beat 2
        clr();
        frameLen = 16'd5; gapLen = 16'd0; lastBytes = 8'd8; frameNum = 16'd1;
        pushFrame(5, 8);
        start = 1'b1;
        waitByte("t3_reach_beat2", 8'h22, 50);
        ready = 1'b0;
        hd = data;
        hk = keep;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_hold_valid", 128'(valid), 128'd1);
            check("t3_hold_data", data, hd);
            check("t3_hold_keep", 128'(keep), 128'(hk));
            check("t3_hold_last", 128'(last), 128'd0);
            check("t3_hold_cnt", 128'(frameCnt), 128'd0);
        end
        ready = 1'b1;
        waitDone("t3_done", 50);
        start = 1'b0;
        tick();
        check("t3_hs", 128'(hsCnt), 128'd5);
        check("t3_lasts", 128'(lastCnt), 128'd1);
        check("t3_sb_empty", 128'(sb.size()), 128'd0);

        // 4: unlimited run, start dropped during beat 1 of len8
        clr();
        frameLen = 16'd8; gapLen = 16'd3; lastBytes = 8'd4; frameNum = 16'd0;
        pushFrame(8, 4);
        start = 1'b1;
        waitByte("t4_reach_beat1", 8'h11, 50);
        start = 1'b0;
        waitDone("t4_done", 50);
        tick();
        tick();
        check("t4_hs", 128'(hsCnt), 128'd8);
        check("t4_done_cnt", 128'(doneCnt), 128'd1);
        check("t4_frame_cnt", 128'(frameCnt), 128'd1);
        check("t4_busy", 128'(busy), 128'd0);
        check("t4_valid_after", 128'(valid), 128'd0);
        check("t4_sb_empty", 128'(sb.size()), 128'd0);

        // 5: len0 / last_bytes 0 -> single full beats
        clr();
        frameLen = 16'd0; gapLen = 16'd0; lastBytes = 8'd0; frameNum = 16'd2;
        for (int f = 0; f < 2; f++) pushFrame(0, 0);
        start = 1'b1;
        waitDone("t5_done", 50);
        start = 1'b0;
        tick();
        check("t5_hs", 128'(hsCnt), 128'd2);
        check("t5_lasts", 128'(lastCnt), 128'd2);
        check("t5_sb_empty", 128'(sb.size()), 128'd0);

        // 6: reset at beat 3 of second len10 frame, then clean restart
        clr();
        frameLen = 16'd10; gapLen = 16'd0; lastBytes = 8'd10; frameNum = 16'd0;
        for (int f = 0; f < 2; f++) pushFrame(10, 10);
        start = 1'b1;
        n = 0;
        while (frameCnt != 16'd1 && n < 50) begin
            tick();
            n++;
        end
        check("t6_first_frame", 128'(frameCnt), 128'd1);
        waitByte("t6_reach_beat3", 8'h33, 50);
        rst = 1'b1;
        ready = 1'b0;
        tick();
        check("t6_rst_valid", 128'(valid), 128'd0);
        check("t6_rst_cnt", 128'(frameCnt), 128'd0);
        check("t6_rst_busy", 128'(busy), 128'd0);
        check("t6_rst_last", 128'(last), 128'd0);
        check("t6_rst_keep", 128'(keep), 128'hFFFF);
        sb.delete();
        clr();
        rst = 1'b0;
        ready = 1'b1;
        frameNum = 16'd1;
        pushFrame(10, 10);
        waitDone("t6_done", 50);
        start = 1'b0;
        tick();
        check("t6_hs", 128'(hsCnt), 128'd10);
        check("t6_lasts", 128'(lastCnt), 128'd1);
        check("t6_frame_cnt", 128'(frameCnt), 128'd1);
        check("t6_sb_empty", 128'(sb.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
